lcd_driver: RTL and testbench



---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_driver.sv | 115 +++++++++++
 tb/tb_lcd_driver.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD driver: FSM states,
// command bytes, the power-up init ROM and the long-command classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    localparam int unsigned CNT_W = 20;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int unsigned INIT_LEN = 6;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        LCD_FUNC_SET, LCD_FUNC_SET, LCD_FUNC_SET, LCD_DISP_ON, LCD_CLEAR, LCD_ENTRY
    };

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == '0) && (data[1:0] != '0);
    endfunction

endpackage

// File: rtl/lcd_driver.sv
// HD44780 bus driver: autonomous power-up init, then one byte per valid/ready
// handshake with setup, enable pulse and post-command execution wait.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned E_PULSE_CYCLES    = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(POWERUP_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 32'd1);
    localparam logic [2:0]       IDX_LAST   = 3'(INIT_LEN - 32'd1);

    lcd_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_init_done;
    logic             r_ready;
    logic [7:0]       r_lcd_data;
    logic             r_lcd_rs;
    logic             r_lcd_e;

    // The counter runs up from its reset value of 0 during power-up so no
    // preload is needed at reset; every other phase loads it and counts down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
            r_lcd_data  <= '0;
            r_lcd_rs    <= 1'b0;
            r_lcd_e     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == PWRUP_LAST) begin
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_lcd_data <= INIT_ROM[0];
                        r_lcd_rs   <= 1'b0;
                        r_state    <= ST_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_lcd_e <= 1'b1;
                    r_cnt   <= PULSE_LAST;
                    r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_lcd_e <= 1'b0;
                        r_cnt   <= is_long_cmd(r_lcd_rs, r_lcd_data) ? CLEAR_LAST : CMD_LAST;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_init_done && (r_idx != IDX_LAST)) begin
                        r_idx      <= r_idx + 1'b1;
                        r_lcd_data <= INIT_ROM[r_idx + 3'd1];
                        r_lcd_rs   <= 1'b0;
                        r_state    <= ST_SETUP;
                    end else begin
                        r_init_done <= 1'b1;
                        r_ready     <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_lcd_data <= req_data;
                        r_lcd_rs   <= req_rs;
                        r_ready    <= 1'b0;
                        r_state    <= ST_SETUP;
                    end
                end
                default: begin
                    r_state <= ST_PWRUP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign lcd_data  = r_lcd_data;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_lcd_e;

endmodule

// File: tb/tb_lcd_driver.sv
// Scoreboard bench for lcd_driver: a cycle-level schedule model predicts every
// enable pulse and the ready window; a monitor checks pulses as they appear.
module tb_lcd_driver;

    localparam int unsigned P_PWR = 20;
    localparam int unsigned P_E   = 3;
    localparam int unsigned P_CMD = 10;
    localparam int unsigned P_CLR = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = '0;
    logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    lcd_driver #(
        .POWERUP_CYCLES   (P_PWR),
        .E_PULSE_CYCLES   (P_E),
        .CMD_WAIT_CYCLES  (P_CMD),
        .CLEAR_WAIT_CYCLES(P_CLR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } item_t;

    item_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         ready_at = 0;
    int         done_at = 0;
    int         n_acc = 0;
    bit         model_on = 1'b0;
    bit         prev_e = 1'b0;
    int         rise_c = 0;
    logic [7:0] init_seq [6];

    // Cycle 1 is the first cycle after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 1;
        else       cyc <= cyc + 1;
    end

    function automatic int wait_len(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) return P_CLR;
        return P_CMD;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, cyc, act, act, exp, exp);
        end
    endtask

    task automatic model_init();
        int t;
        item_t it;
        exp_q.delete();
        t = P_PWR + 2;
        for (int k = 0; k < 6; k++) begin
            it.rs   = 1'b0;
            it.data = init_seq[k];
            it.rise = t;
            exp_q.push_back(it);
            t = t + P_E + wait_len(1'b0, init_seq[k]) + 1;
        end
        ready_at = t - 1;
        done_at  = t - 1;
        model_on = 1'b1;
    endtask

    // Reference model: ready window, init_done, and accepted-byte schedule.
    always @(negedge clk) begin
        if (!reset && model_on) begin
            bit    exp_rdy;
            item_t it;
            exp_rdy = (cyc >= ready_at);
            check("req_ready", int'(req_ready), int'(exp_rdy));
            check("init_done", int'(init_done), int'(cyc >= done_at));
            check("lcd_rw", int'(lcd_rw), 0);
            if (exp_rdy && req_valid) begin
                it.rs   = req_rs;
                it.data = req_data;
                it.rise = cyc + 2;
                exp_q.push_back(it);
                ready_at = cyc + 2 + P_E + wait_len(req_rs, req_data);
                n_acc++;
            end
        end
    end

    // Monitor: every lcd_e rise is matched against the next expected byte.
    always @(negedge clk) begin
        if (reset || !model_on) begin
            prev_e = 1'b0;
        end else begin
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("rise_cycle", cyc, it.rise);
                    check("pulse_data", int'(lcd_data), int'(it.data));
                    check("pulse_rs", int'(lcd_rs), int'(it.rs));
                end
                rise_c = cyc;
            end
            if (!lcd_e && prev_e) check("pulse_width", cyc - rise_c, P_E);
            prev_e = lcd_e;
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cyc >= ready_at) return;
        end
        check("timeout_idle", 1, 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int budget);
        int start;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        start     = n_acc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_acc != start) break;
            if (i == budget - 1) check("timeout_accept", 1, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start;
        init_seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

        repeat (3) @(posedge clk);
        #1;
        check("reset_e", int'(lcd_e), 0);
        check("reset_data", int'(lcd_data), 0);
        check("reset_ready", int'(req_ready), 0);
        check("reset_done", int'(init_done), 0);
        reset = 1'b0;
        model_init();
        wait_idle(1000);

        send(1'b1, 8'h41, 50);
        wait_idle(200);

        send(1'b0, 8'h01, 50); wait_idle(200);
        send(1'b0, 8'h02, 50); wait_idle(200);
        send(1'b0, 8'h80, 50); wait_idle(200);
        send(1'b1, 8'h01, 50); wait_idle(200);

        // Held valid with data changing every cycle.
        start = n_acc;
        for (int i = 0; i < 400 && (n_acc - start) < 8; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_rs    = 1'($urandom);
            req_data  = 8'($urandom);
        end
        check("held_valid_bytes", n_acc - start, 8);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle(200);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'($urandom_range(0, 3) == 0);
            req_rs    = 1'($urandom);
            req_data  = 8'($urandom_range(0, 7));
        end
        req_valid = 1'b0;
        wait_idle(200);

        // Asynchronous reset in the middle of a data pulse.
        send(1'b1, 8'h7E, 50);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lcd_e) break;
            if (i == 49) check("timeout_pulse", 1, 0);
        end
        #1;
        reset    = 1'b1;
        model_on = 1'b0;
        #1;
        check("async_e", int'(lcd_e), 0);
        check("async_ready", int'(req_ready), 0);
        check("async_done", int'(init_done), 0);
        check("async_data", int'(lcd_data), 0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
        start = n_acc;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_acc != start) break;
            if (i == 999) check("timeout_early_valid", 1, 0);
        end
        check("early_valid_accept_cycle", ready_at - 2 - P_E - P_CMD, done_at);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_idle(200);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
